// File: rtl/mult_accum_ctrl_pkg.sv
// Shared widths, constants and FSM state encoding for the shift-and-add multiplier.
package mult_accum_ctrl_pkg;
  localparam int DW   = 16;
  localparam int DW_2 = 2 * DW;
  localparam int CW   = $clog2(DW + 1);

  localparam logic [DW_2-1:0] ZERO     = '0;
  localparam logic [CW-1:0]   ONE      = CW'(1);
  localparam logic            BIT_ZERO = 1'b0;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} mult_state_e;
endpackage

// File: rtl/mplier_right_shift.sv
// Multiplier operand register: parallel load, logical shift right, exposes bit 0.
// Single-cycle update; no flow control (load wins over shift).
module mplier_right_shift
  import mult_accum_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [DW-1:0] din_i,
  output logic          lsb_o
);

  logic [DW-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {BIT_ZERO, sr_q[DW-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign lsb_o = sr_q[0];

endmodule

// File: rtl/mult_accum_ctrl.sv
// Control FSM and accumulator of the shift-and-add multiplier; done pulses DW+1
// edges after start is sampled in IDLE. Fixed latency, starts outside IDLE are dropped.
module mult_accum_ctrl
  import mult_accum_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   multiplier,
  input  logic [DW_2-1:0] shift_in,
  output logic            permit,
  output logic [DW_2-1:0] product,
  output logic            busy,
  output logic            done
);

  mult_state_e     state_q, state_d;
  logic [DW_2-1:0] acc_q, acc_d;
  logic [DW_2-1:0] product_q, product_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mp_load, mp_shift, mp_lsb;
  logic [DW_2-1:0] sum;

  mplier_right_shift u_mplier (
    .clk     (clk),
    .rst     (rst),
    .load_i  (mp_load),
    .shift_i (mp_shift),
    .din_i   (multiplier),
    .lsb_o   (mp_lsb)
  );

  // The adder wraps modulo 2^DW_2; no carry out is kept.
  assign sum = acc_q + (mp_lsb ? shift_in : ZERO);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    mp_load   = 1'b0;
    mp_shift  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mp_load = 1'b1;
          acc_d   = ZERO;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        acc_d    = sum;
        mp_shift = 1'b1;
        cnt_d    = cnt_q + ONE;
        // No early exit on a zero multiplier: latency stays fixed.
        if (cnt_q == CW'(DW - 1)) begin
          product_d = sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= ZERO;
      cnt_q     <= '0;
      product_q <= ZERO;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Outputs decode registered state only.
  assign permit  = (state_q == RUN);
  assign busy    = (state_q == LOAD) || (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult_accum_ctrl.sv
// Bench for mult_accum_ctrl with a behavioural left-shift stage closing the permit loop.
module tb_mult_accum_ctrl;
  import mult_accum_ctrl_pkg::*;

  logic            clk;
  logic            rst;
  logic            start;
  logic [DW-1:0]   multiplier;
  logic [DW-1:0]   mcand;
  logic [DW_2-1:0] shift_in;
  logic            permit;
  logic [DW_2-1:0] product;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;

  mult_accum_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .multiplier (multiplier),
    .shift_in   (shift_in),
    .permit     (permit),
    .product    (product),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Left-shift stage: reload the zero-extended multiplicand while permit is low.
  logic [DW_2-1:0] sh_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sh_q <= '0;
    else if (!permit) sh_q <= {{DW{1'b0}}, mcand};
    else sh_q <= sh_q << 1;
  end
  assign shift_in = sh_q;

  typedef struct {
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [DW_2-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One operation: start sampled at edge 0; start is re-driven from poke[k] after edge k.
  task automatic run_op(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW_2-1:0] exp, input logic [31:0] poke);
    int busy_n, permit_n, done_n, done_at;
    mcand      = a;
    multiplier = b;
    start      = 1'b1;
    @(posedge clk); #1;
    start    = poke[0];
    busy_n   = int'(busy);
    permit_n = int'(permit);
    done_n   = int'(done);
    done_at  = -1;
    for (int k = 1; k < 30; k++) begin
      @(posedge clk); #1;
      start = poke[k];
      busy_n   += int'(busy);
      permit_n += int'(permit);
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = k;
          chk({name, " product@done"}, product, exp);
        end
      end
    end
    start = 1'b0;
    chk({name, " done edge"}, done_at, 32'd17);
    chk({name, " done count"}, done_n, 32'd1);
    chk({name, " busy cycles"}, busy_n, 32'd17);
    chk({name, " permit cycles"}, permit_n, 32'd16);
    chk({name, " product held"}, product, exp);
  endtask

  initial begin
    int done_n, d1, d2;
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[3] = '{16'h0000, 16'h8000, 32'h0000_0000};
    vecs[4] = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[6] = '{16'hABCD, 16'h0001, 32'h0000_ABCD};

    rst        = 1'b0;
    start      = 1'b0;
    mcand      = '0;
    multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset product", product, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset permit", 32'(permit), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 32'h0);
    end

    // Re-pulses in LOAD, mid-RUN and DONE must all be dropped.
    run_op("repulse", 16'h0007, 16'h0009, 32'h0000_003F, 32'h0002_0021);
    run_op("after repulse", 16'h0011, 16'h0011, 32'h0000_0121, 32'h0);

    // Start held high: back-to-back operations with one IDLE cycle between them.
    mcand      = 16'h0002;
    multiplier = 16'h0003;
    start      = 1'b1;
    done_n = 0; d1 = -1; d2 = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (k == 39) start = 1'b0;
      if (done) begin
        done_n++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
        chk("held product", product, 32'h0000_0006);
      end
    end
    chk("held first done", d1, 32'd17);
    chk("held second done", d2, 32'd36);
    chk("held done count", done_n, 32'd3);

    // Reset mid-RUN aborts the operation without a done.
    mcand      = 16'h00FF;
    multiplier = 16'h00FF;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre-reset permit", 32'(permit), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort permit", 32'(permit), 32'h0);
    chk("abort product", product, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    done_n = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      done_n += int'(done);
    end
    chk("abort no done", done_n, 32'd0);
    run_op("fresh", 16'h00FF, 16'h00FF, 32'h0000_FE01, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
